// File: rtl/branch_resolve.sv
// Condition-code register and branch resolution unit.
// Captures ALU z/v/n flags, counts in-flight flag writers, and resolves one
// branch at a time once the flags are final (IDLE -> WAIT -> RESP).
// Optional feature: define BRANCH_STATS_EN to add stat_total_o / stat_taken_o
// resolution counters.
module branch_resolve #(
  parameter int unsigned PEND_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flag_issue_i,
  input  logic        flag_we_i,
  input  logic        z_i,
  input  logic        v_i,
  input  logic        n_i,
  input  logic        br_valid_i,
  output logic        br_ready_o,
  input  logic [2:0]  br_cond_i,
  input  logic [31:0] br_pc_i,
  input  logic [31:0] br_offset_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic        res_taken_o,
  output logic [31:0] res_pc_o,
  output logic [2:0]  flags_o,
  output logic        err_ovf_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_total_o,
  output logic [31:0] stat_taken_o
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [PEND_W-1:0] PendMax = '1;

  state_e             state_q, state_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic [2:0]         flags_q, flags_d;
  logic [2:0]         cond_q, cond_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        off_q, off_d;
  logic               res_taken_q, res_taken_d;
  logic [31:0]        res_pc_q, res_pc_d;
  logic               flags_final;
  logic               cond_true;

  // Flags in the register are final only when no writer is outstanding and
  // none lands this cycle; a same-cycle write defers evaluation by one cycle.
  assign flags_final = (pend_q == '0) && !flag_we_i;

  function automatic logic eval_cond(input logic [2:0] cond, input logic z, input logic v,
                                     input logic n);
    logic r;
    unique case (cond)
      3'b000:  r = !z;
      3'b001:  r = z;
      3'b010:  r = !z && (n == v);
      3'b011:  r = (n != v);
      3'b100:  r = (n == v);
      3'b101:  r = z || (n != v);
      3'b110:  r = v;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  assign cond_true = eval_cond(cond_q, flags_q[2], flags_q[1], flags_q[0]);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      ovf_q       <= 1'b0;
      flags_q     <= 3'b000;
      cond_q      <= 3'b000;
      pc_q        <= 32'd0;
      off_q       <= 32'd0;
      res_taken_q <= 1'b0;
      res_pc_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      flags_q     <= flags_d;
      cond_q      <= cond_d;
      pc_q        <= pc_d;
      off_q       <= off_d;
      res_taken_q <= res_taken_d;
      res_pc_q    <= res_pc_d;
    end
  end

  // Pending counter with saturation, sticky overflow, and flag capture.
  always_comb begin
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    flags_d = flags_q;
    if (flag_we_i) begin
      flags_d = {z_i, v_i, n_i};
    end
    if (flag_issue_i && !flag_we_i) begin
      if (pend_q == PendMax) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (flag_we_i && !flag_issue_i && (pend_q != '0)) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (br_valid_i) state_d = StWait;
      StWait:  if (flags_final) state_d = StResp;
      StResp:  if (res_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    br_ready_o  = 1'b0;
    res_valid_o = 1'b0;
    unique case (state_q)
      StIdle:  br_ready_o  = 1'b1;
      StResp:  res_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Branch latch on acceptance and result capture on evaluation.
  always_comb begin
    cond_d      = cond_q;
    pc_d        = pc_q;
    off_d       = off_q;
    res_taken_d = res_taken_q;
    res_pc_d    = res_pc_q;
    if (state_q == StIdle && br_valid_i) begin
      cond_d = br_cond_i;
      pc_d   = br_pc_i;
      off_d  = br_offset_i;
    end
    if (state_q == StWait && flags_final) begin
      res_taken_d = cond_true;
      res_pc_d    = cond_true ? (pc_q + off_q) : (pc_q + 32'd4);
    end
  end

  assign res_taken_o = res_taken_q;
  assign res_pc_o    = res_pc_q;
  assign flags_o     = flags_q;
  assign err_ovf_o   = ovf_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_total_q, stat_total_d;
  logic [31:0] stat_taken_q, stat_taken_d;

  // Resolution counters, bumped on each completed result handshake.
  always_comb begin
    stat_total_d = stat_total_q;
    stat_taken_d = stat_taken_q;
    if (state_q == StResp && res_ready_i) begin
      stat_total_d = stat_total_q + 32'd1;
      stat_taken_d = stat_taken_q + {31'd0, res_taken_q};
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_total_q <= 32'd0;
      stat_taken_q <= 32'd0;
    end else begin
      stat_total_q <= stat_total_d;
      stat_taken_q <= stat_taken_d;
    end
  end

  assign stat_total_o = stat_total_q;
  assign stat_taken_o = stat_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus a randomized
// run checked every cycle against a behavioural model of flags, pending count
// and the one-branch-at-a-time resolution protocol.
module tb_branch_resolve;

  localparam int PEND_MAX = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag_issue, flag_we, z, v, n;
  logic        br_valid, br_ready;
  logic [2:0]  br_cond;
  logic [31:0] br_pc, br_offset;
  logic        res_valid, res_ready, res_taken;
  logic [31:0] res_pc;
  logic [2:0]  flags;
  logic        err_ovf;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_total, stat_taken;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state.
  int          m_pend;
  bit [2:0]    m_flags;
  bit          m_ovf;
  int          m_phase;  // 0 accepting, 1 awaiting final flags, 2 presenting result
  bit [2:0]    m_cond;
  bit [31:0]   m_bpc, m_boff;
  bit          m_taken;
  bit [31:0]   m_pc;
  bit [31:0]   m_total, m_tkn;

  branch_resolve #(.PEND_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flag_issue_i(flag_issue),
    .flag_we_i   (flag_we),
    .z_i         (z),
    .v_i         (v),
    .n_i         (n),
    .br_valid_i  (br_valid),
    .br_ready_o  (br_ready),
    .br_cond_i   (br_cond),
    .br_pc_i     (br_pc),
    .br_offset_i (br_offset),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_taken_o (res_taken),
    .res_pc_o    (res_pc),
    .flags_o     (flags),
    .err_ovf_o   (err_ovf)
`ifdef BRANCH_STATS_EN
    ,
    .stat_total_o(stat_total),
    .stat_taken_o(stat_taken)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit branch_taken(input bit [2:0] c, input bit [2:0] f);
    bit fz, fv, fn;
    fz = f[2]; fv = f[1]; fn = f[0];
    case (c)
      3'd0: return !fz;
      3'd1: return fz;
      3'd2: return !fz && (fn == fv);
      3'd3: return fn != fv;
      3'd4: return fn == fv;
      3'd5: return fz || (fn != fv);
      3'd6: return fv;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_flags = 3'b000; m_ovf = 1'b0; m_phase = 0;
    m_taken = 1'b0; m_pc = 32'd0; m_total = 32'd0; m_tkn = 32'd0;
  endtask

  // Advance one clock: update the model from the inputs present at the edge,
  // then settle 1 time unit past the edge for sampling.
  task automatic tick();
    bit issue, we;
    issue = flag_issue;
    we    = flag_we;
    case (m_phase)
      0: if (br_valid) begin
           m_cond = br_cond; m_bpc = br_pc; m_boff = br_offset; m_phase = 1;
         end
      1: if (m_pend == 0 && !we) begin
           m_taken = branch_taken(m_cond, m_flags);
           m_pc    = m_taken ? m_bpc + m_boff : m_bpc + 32'd4;
           m_phase = 2;
         end
      default: if (res_ready) begin
           m_total = m_total + 1;
           m_tkn   = m_tkn + (m_taken ? 1 : 0);
           m_phase = 0;
         end
    endcase
    if (we) m_flags = {z, v, n};
    if (issue && !we) begin
      if (m_pend == PEND_MAX) m_ovf = 1'b1;
      else m_pend = m_pend + 1;
    end else if (we && !issue && m_pend > 0) begin
      m_pend = m_pend - 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flag_issue = 0; flag_we = 0; z = 0; v = 0; n = 0;
    br_valid = 0; br_cond = 0; br_pc = 0; br_offset = 0; res_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic write_flags(input bit fz, input bit fv, input bit fn);
    flag_we = 1; z = fz; v = fv; n = fn;
    tick();
    flag_we = 0;
  endtask

  task automatic send_branch(input bit [2:0] c, input bit [31:0] pc, input bit [31:0] off);
    br_valid = 1; br_cond = c; br_pc = pc; br_offset = off;
    tick();
    br_valid = 0;
  endtask

  task automatic take_result();
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (br_ready !== 1'b1) begin n_bad++; $display("FAIL reset_br_ready got %b want 1", br_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    n_cmp++; if (res_taken !== 1'b0) begin n_bad++; $display("FAIL reset_res_taken got %b want 0", res_taken); end
    n_cmp++; if (res_pc !== 32'd0) begin n_bad++; $display("FAIL reset_res_pc got %h want 0", res_pc); end
    n_cmp++; if (flags !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", flags); end
    n_cmp++; if (err_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_err_ovf got %b want 0", err_ovf); end
    do_reset();
  endtask

  task automatic test_eq_no_pending();
    write_flags(1, 0, 0);
    n_cmp++; if (flags !== 3'b100) begin n_bad++; $display("FAIL eq_flags got %b want 100", flags); end
    send_branch(3'b001, 32'h100, 32'h20);
    n_cmp++; if (br_ready !== 1'b0 || res_valid !== 1'b0) begin
      n_bad++; $display("FAIL eq_cycle1 got ready=%b valid=%b want 0/0", br_ready, res_valid);
    end
    tick();
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL eq_valid got %b want 1", res_valid); end
    n_cmp++; if (res_taken !== 1'b1) begin n_bad++; $display("FAIL eq_taken got %b want 1", res_taken); end
    n_cmp++; if (res_pc !== 32'h120) begin n_bad++; $display("FAIL eq_pc got %h want 120", res_pc); end
    take_result();
    n_cmp++; if (br_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_bad++; $display("FAIL eq_done got ready=%b valid=%b want 1/0", br_ready, res_valid);
    end
  endtask

  task automatic test_pending_stall();
    bit early;
    early = 0;
    flag_issue = 1;
    tick(); tick();
    flag_issue = 0;
    send_branch(3'b000, 32'h200, 32'h40);
    for (int k = 0; k < 2; k++) begin
      repeat (3) begin tick(); if (res_valid !== 1'b0) early = 1; end
      write_flags(0, 0, 0);
      if (res_valid !== 1'b0) early = 1;
    end
    n_cmp++; if (early) begin n_bad++; $display("FAIL stall_early got res_valid=1 want 0 before flags final"); end
    tick();
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid got %b want 1", res_valid); end
    n_cmp++; if (res_taken !== 1'b1) begin n_bad++; $display("FAIL stall_taken got %b want 1", res_taken); end
    n_cmp++; if (res_pc !== 32'h240) begin n_bad++; $display("FAIL stall_pc got %h want 240", res_pc); end
    take_result();
  endtask

  task automatic test_lt_wrap();
    write_flags(1, 0, 0);
    send_branch(3'b011, 32'hFFFF_FFFC, 32'h1000);
    tick();
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL lt_valid got %b want 1", res_valid); end
    n_cmp++; if (res_taken !== 1'b0) begin n_bad++; $display("FAIL lt_taken got %b want 0", res_taken); end
    n_cmp++; if (res_pc !== 32'h0) begin n_bad++; $display("FAIL lt_wrap_pc got %h want 00000000", res_pc); end
    take_result();
  endtask

  task automatic test_backpressure();
    bit held;
    held = 1;
    write_flags(1, 0, 0);
    send_branch(3'b001, 32'h300, 32'h10);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) write_flags(0, 1, 1);
      else tick();
      if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_pc !== 32'h310 || br_ready !== 1'b0)
        held = 0;
    end
    n_cmp++; if (!held) begin
      n_bad++; $display("FAIL bp_hold got valid=%b taken=%b pc=%h ready=%b want 1/1/310/0",
                        res_valid, res_taken, res_pc, br_ready);
    end
    n_cmp++; if (flags !== 3'b011) begin n_bad++; $display("FAIL bp_flags got %b want 011", flags); end
    take_result();
  endtask

  task automatic test_saturation();
    do_reset();
    flag_issue = 1;
    repeat (7) tick();
    n_cmp++; if (err_ovf !== 1'b0) begin n_bad++; $display("FAIL sat_ovf_early got %b want 0", err_ovf); end
    tick();
    flag_issue = 0;
    n_cmp++; if (err_ovf !== 1'b1) begin n_bad++; $display("FAIL sat_ovf got %b want 1", err_ovf); end
    flag_issue = 1; flag_we = 1; z = 0; v = 1; n = 0;
    tick();
    flag_issue = 0; flag_we = 0;
    send_branch(3'b111, 32'h400, 32'h8);
    // Seven writers outstanding: the branch resolves only after the seventh.
    for (int i = 0; i < 7; i++) begin
      write_flags(1'($urandom_range(1, 0)), 0, 0);
      tick();
      n_cmp++; if (res_valid !== (i == 6)) begin
        n_bad++; $display("FAIL sat_drain_%0d got res_valid=%b want %b", i, res_valid, (i == 6));
      end
    end
    n_cmp++; if (res_pc !== 32'h408 || err_ovf !== 1'b1) begin
      n_bad++; $display("FAIL sat_result got pc=%h ovf=%b want 408/1", res_pc, err_ovf);
    end
    take_result();
  endtask

  task automatic test_reset_mid_wait();
    write_flags(1, 0, 1);
    flag_issue = 1;
    tick(); tick();
    flag_issue = 0;
    send_branch(3'b111, 32'h500, 32'h4);
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (br_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_wait_hs got ready=%b valid=%b want 1/0", br_ready, res_valid);
    end
    n_cmp++; if (flags !== 3'b000 || err_ovf !== 1'b0) begin
      n_bad++; $display("FAIL rst_wait_state got flags=%b ovf=%b want 000/0", flags, err_ovf);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_branch(3'b111, 32'h600, 32'h30);
    tick();
    n_cmp++; if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_pc !== 32'h630) begin
      n_bad++; $display("FAIL rst_wait_al got valid=%b taken=%b pc=%h want 1/1/630",
                        res_valid, res_taken, res_pc);
    end
    take_result();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      flag_issue = ($urandom_range(2, 0) == 0);
      flag_we    = ($urandom_range(2, 0) == 0);
      z = 1'($urandom); v = 1'($urandom); n = 1'($urandom);
      br_valid  = 1'($urandom);
      br_cond   = 3'($urandom_range(7, 0));
      br_pc     = $urandom;
      br_offset = ($urandom_range(3, 0) == 0) ? $urandom : 32'($urandom_range(255, 0)) << 2;
      res_ready = 1'($urandom);
      tick();
      n_cmp++; if (br_ready !== (m_phase == 0) || res_valid !== (m_phase == 2)) begin
        n_bad++; $display("FAIL rand_hs_%0d got ready=%b valid=%b want %b/%b", c, br_ready,
                          res_valid, (m_phase == 0), (m_phase == 2));
      end
      n_cmp++; if (res_taken !== m_taken || res_pc !== m_pc) begin
        n_bad++; $display("FAIL rand_res_%0d got taken=%b pc=%h want %b/%h", c, res_taken,
                          res_pc, m_taken, m_pc);
      end
      n_cmp++; if (flags !== m_flags || err_ovf !== m_ovf) begin
        n_bad++; $display("FAIL rand_flags_%0d got flags=%b ovf=%b want %b/%b", c, flags,
                          err_ovf, m_flags, m_ovf);
      end
`ifdef BRANCH_STATS_EN
      n_cmp++; if (stat_total !== m_total || stat_taken !== m_tkn) begin
        n_bad++; $display("FAIL rand_stats_%0d got %0d/%0d want %0d/%0d", c, stat_total,
                          stat_taken, m_total, m_tkn);
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_eq_no_pending();
    test_pending_stall();
    test_lt_wrap();
    test_backpressure();
    test_saturation();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Condition-code register and branch resolution unit that sits downstream of the ALU. It captures the z/v/n flags the ALU produces and tracks flag-writing instructions still in flight. It accepts branch requests over a valid/ready handshake, stalls each branch until the flags are final, then evaluates the branch condition. It returns the taken decision and next PC over a second valid/ready handshake.

## Interface
- PEND_W, 3, width of the in-flight flag-writer counter (max outstanding = 2^PEND_W − 1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flag_issue  in  1  a flag-writing instruction has issued (pending +1)
- flag_we  in  1  ALU flag write-back this cycle (pending −1, capture flags)
- z_in, v_in, n_in  in  1 each  ALU zero/overflow/negative flags
- br_valid  in  1  branch request valid
- br_ready  out  1  unit can accept a branch
- br_cond  in  3  condition code
- br_pc  in  32  PC of branch
- br_offset  in  32  two's-complement target offset
- res_valid  out  1  resolution valid
- res_ready  in  1  consumer accepts resolution
- res_taken  out  1  branch taken
- res_pc  out  32  next PC
- flags  out  3  registered {z,v,n}
- err_ovf  out  1  sticky: flag_issue dropped at counter saturation

## Operation
- Flag register: on flag_we, {z,v,n} ← {z_in,v_in,n_in}, visible on `flags` the next cycle.
- Pending counter: +1 on flag_issue only, −1 on flag_we only, unchanged when both or neither are asserted.
- At max, a flag_issue without flag_we is ignored and err_ovf is set. err_ovf clears only on reset.
- At 0, a flag_we without flag_issue still captures the flags, and the counter stays 0.
- Condition codes:
  - 000 NE: !z
  - 001 EQ: z
  - 010 GT: !z & (n==v)
  - 011 LT: n!=v
  - 100 GE: n==v
  - 101 LE: z | (n!=v)
  - 110 OV: v
  - 111 AL: 1
- FSM states are IDLE, WAIT and RESP.
  - IDLE: br_ready=1. On br_valid, latch cond/pc/offset and go to WAIT.
  - WAIT: br_ready=0. When pending==0 and flag_we==0, evaluate the condition against the flag register, register res_taken/res_pc, and go to RESP. Otherwise stay in WAIT.
  - RESP: res_valid=1, with res_taken and res_pc held stable. On res_ready, go to IDLE.
- res_pc = taken ? br_pc + br_offset : br_pc + 4, 32-bit, wrapping mod 2^32.
- Reset (any state): FSM→IDLE, pending=0, flags=000, err_ovf=0, res_taken=0, res_pc=0. Any in-flight branch is dropped.

## Timing
- Reset values: br_ready=1, res_valid=0, res_taken=0, res_pc=0, flags=000, err_ovf=0.
- Minimum latency is 2 cycles.
  - Handshake in cycle 0.
  - WAIT evaluates in cycle 1.
  - res_valid=1 in cycle 2.
- Each pending decrement or concurrent flag_we adds ≥1 cycle.
- A flag_we in the same cycle as the WAIT check defers evaluation by one cycle, so the new flags are used.
- One branch at a time; br_ready returns the cycle after the res handshake.
- Maximum throughput is one branch per 3 cycles.
- res_valid must not drop, and outputs must not change, until res_ready.
- flag_issue and flag_we are honoured in every state, including RESP.

## Configuration
- BRANCH_STATS_EN defined: adds outputs stat_total[31:0] and stat_taken[31:0].
  - Both reset to 0.
  - stat_total increments on each res handshake; stat_taken increments on each res handshake with res_taken=1.
  - Both wrap at 2^32.
- BRANCH_STATS_EN undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- **EQ, no pending:**
  - Stimulus: flag_we with z=1; then branch cond=001, pc=0x100, offset=0x20.
  - Required: res_valid 2 cycles after acceptance, res_taken=1, res_pc=0x120.
- **Pending stall:**
  - Stimulus: flag_issue ×2; branch cond=000, pc=0x200; then flag_we with z=0 twice, 3 cycles apart.
  - Required: no res_valid until after the second flag_we; then res_taken=1, res_pc=0x200+offset.
- **Not-taken, LT, wrap:**
  - Stimulus: flags n=0, v=0; cond=011, pc=0xFFFF_FFFC.
  - Required: res_taken=0, res_pc=0x0000_0000.
- **Backpressure:**
  - Stimulus: res_ready=0 for 5 cycles while a flag_we changes the flags.
  - Required: res_valid, res_taken and res_pc held stable; br_ready=0 throughout; flags register still updates.
- **Saturation and simultaneity:**
  - Stimulus (PEND_W=3): 7 flag_issue, then an 8th alone, then flag_issue+flag_we together.
  - Required: pending stays 7 and err_ovf=1 after the 8th; pending stays 7 after the simultaneous cycle.
- **Reset mid-WAIT:**
  - Stimulus: assert rst_n=0 with pending=2 and the FSM in WAIT.
  - Required: immediately br_ready=1, res_valid=0, flags=000; after release, a cond=111 branch resolves taken in 2 cycles.
